// File: rtl/data_memory_responder_if.sv
// Data-memory request/response bundle between the MEM stage (master) and the
// data memory (slave).
//   dm_req_valid/dm_write_enable/addresses/dm_write_data : request, master -> slave
//   dm_byte_en (DM_BYTE_ENABLE_EN builds only)            : write byte lanes
//   dm_read_data/dm_resp_valid/dm_busy/dm_addr_error      : response, slave -> master
// Optional feature macro: DM_BYTE_ENABLE_EN.
interface data_memory_responder_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              dm_req_valid;
  logic              dm_write_enable;
  logic [ADDR_W-1:0] dm_write_address;
  logic [DATA_W-1:0] dm_write_data;
  logic [ADDR_W-1:0] dm_read_address;
  logic [DATA_W-1:0] dm_read_data;
  logic              dm_resp_valid;
  logic              dm_busy;
  logic              dm_addr_error;
`ifdef DM_BYTE_ENABLE_EN
  logic [DATA_W/8-1:0] dm_byte_en;

  modport master (
    output dm_req_valid, dm_write_enable, dm_write_address, dm_write_data,
           dm_read_address, dm_byte_en,
    input  dm_read_data, dm_resp_valid, dm_busy, dm_addr_error
  );
  modport slave (
    input  dm_req_valid, dm_write_enable, dm_write_address, dm_write_data,
           dm_read_address, dm_byte_en,
    output dm_read_data, dm_resp_valid, dm_busy, dm_addr_error
  );
`else
  modport master (
    output dm_req_valid, dm_write_enable, dm_write_address, dm_write_data,
           dm_read_address,
    input  dm_read_data, dm_resp_valid, dm_busy, dm_addr_error
  );
  modport slave (
    input  dm_req_valid, dm_write_enable, dm_write_address, dm_write_data,
           dm_read_address,
    output dm_read_data, dm_resp_valid, dm_busy, dm_addr_error
  );
`endif
endinterface

// File: rtl/data_memory_responder.sv
// Word-organised data memory answering MEM-stage requests with a fixed
// multi-cycle latency. One access in flight at a time; requests arriving while
// busy are dropped.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset (array contents are not reset)
//   dm    : slave side of data_memory_responder_if
// Optional feature macro: DM_BYTE_ENABLE_EN (per-byte write enables).
module data_memory_responder #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2   // 1..15
) (
  input  logic                    clock,
  input  logic                    reset,
  data_memory_responder_if.slave  dm
);

  localparam int unsigned Depth    = 1 << DEPTH_LOG2;
  localparam int unsigned NumBytes = DATA_W / 8;
  localparam logic [3:0]  CntInit  = 4'(LATENCY - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic                    err_q, err_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    resp_q, resp_d;
  logic                    aerr_q, aerr_d;
  logic [NumBytes-1:0]     be_q, be_d;

  logic [DATA_W-1:0]       mem_q [Depth];

  logic [ADDR_W-1:0]       req_addr;
  logic                    req_err;
  logic                    complete;
  logic                    mem_we;

  // Only the address belonging to the request type is checked.
  assign req_addr = dm.dm_write_enable ? dm.dm_write_address : dm.dm_read_address;
  assign req_err  = (req_addr[1:0] != 2'b00) || ((req_addr >> (DEPTH_LOG2 + 2)) != '0);
  assign complete = (state_q == StWait) && (cnt_q == 4'd0);
  assign mem_we   = complete && we_q && !err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    resp_d  = 1'b0;
    aerr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dm.dm_req_valid) begin
          we_d    = dm.dm_write_enable;
          err_d   = req_err;
          idx_d   = req_addr[DEPTH_LOG2+1:2];
          wdata_d = dm.dm_write_data;
`ifdef DM_BYTE_ENABLE_EN
          be_d    = dm.dm_byte_en;
`else
          be_d    = '1;
`endif
          cnt_d   = CntInit;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StIdle;
          resp_d  = 1'b1;
          aerr_d  = err_q;
          if (!we_q) rdata_d = err_q ? '0 : mem_q[idx_q];
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      aerr_q  <= aerr_d;
    end
  end

  // Storage array: no reset; write committed on the completion edge only, so an
  // access aborted by reset never lands.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < int'(NumBytes); b++) begin
        if (be_q[b]) mem_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

  assign dm.dm_read_data  = rdata_q;
  assign dm.dm_resp_valid = resp_q;
  assign dm.dm_busy       = (state_q == StWait);
  assign dm.dm_addr_error = aerr_q;

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Word-organised data memory that answers the pipeline MEM stage's data-memory requests (dm_* interface) with a configurable, multi-cycle access latency.
- Holds the storage array, sequences each request through a small FSM, and returns read data with a response pulse.
- Drives dm_busy, which the MEM stage uses as its stall source while an access is outstanding.

Parameters:
- DATA_W, 32, data word width (matches DATA_SIZE).
- ADDR_W, 32, byte-address width (matches ADDRESS_SIZE).
- DEPTH_LOG2, 10, log2 of array depth in words (default 1024 words).
- LATENCY, 2, cycles from accept edge to completion edge; legal range 1..15.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- dm_req_valid  in  1  request strobe, sampled only in IDLE.
- dm_write_enable  in  1  1 = write request, 0 = read request (qualified by dm_req_valid).
- dm_write_address  in  ADDR_W  byte address for writes.
- dm_write_data  in  DATA_W  write data.
- dm_read_address  in  ADDR_W  byte address for reads.
- dm_read_data  out  DATA_W  read data; updated only on read completion, then held.
- dm_resp_valid  out  1  one-cycle pulse on every completion (read or write).
- dm_busy  out  1  high from accept until completion; stall to MEM stage.
- dm_addr_error  out  1  one-cycle pulse with dm_resp_valid when the accepted address was illegal.

Behaviour:
- Reset: asynchronous and active-high. While asserted: state=IDLE, counter=0, dm_read_data=0, dm_resp_valid=0, dm_busy=0, dm_addr_error=0. Array contents are not reset.
- Reset mid-access: the access is aborted, a pending write is not committed, and no response is produced.
- Word index = addr[DEPTH_LOG2+1:2].
- Illegal address: addr[1:0]!=0, or any bit of addr[ADDR_W-1:DEPTH_LOG2+2] set. Only the address of the request type is checked.
- FSM states: IDLE, WAIT.
  - IDLE: dm_req_valid=1 at edge T -> latch type, address, data and error flag; counter=LATENCY-1; go to WAIT. dm_busy=1 after edge T.
  - WAIT with counter!=0: decrement the counter; dm_req_valid is ignored.
  - WAIT with counter==0 (edge T+LATENCY): complete the access, pulse dm_resp_valid for one cycle, dm_busy=0, go to IDLE.
- Completion actions:
  - Legal write: commit array[idx]=data.
  - Legal read: dm_read_data=array[idx].
  - Illegal access: write suppressed, dm_read_data=0, dm_addr_error pulses.
- Latency: the response is visible in the cycle after edge T+LATENCY. With LATENCY=1, dm_busy is high for exactly one cycle.
- Throughput: no request is accepted on a completion edge. The minimum spacing between accepts is LATENCY+1 cycles.
- Requests presented while busy are dropped, not queued. Holding dm_req_valid high therefore yields back-to-back accesses at the minimum spacing.
- Read-after-write to the same word returns the new data, because the write is committed before the read is accepted.
- Inputs are sampled only on the accept edge; input changes during WAIT have no effect.

Optional Feature:
- Macro DM_BYTE_ENABLE_EN.
- Defined: adds input dm_byte_en [DATA_W/8-1:0], latched at accept. A write updates only the enabled bytes. A write with all enables 0 completes (dm_resp_valid pulses) without modifying the array. Reads ignore dm_byte_en.
- Undefined: the port is absent and every write updates the full word.

Test Plan:
- Reset then idle: reset=1 mid-cycle, with no clock edge -> all outputs 0 immediately; dm_busy stays 0 with dm_req_valid=0.
- Basic write/read, LATENCY=2:
  - Write 0xDEADBEEF to 0x00000010 accepted at edge T -> dm_busy=1 for 2 cycles, dm_resp_valid pulse after edge T+2.
  - Read of 0x10 accepted 3 cycles later -> dm_read_data=0xDEADBEEF with dm_resp_valid after its edge T+2.
- Busy drop: while in WAIT, pulse dm_req_valid with a write of 0x11111111 to 0x20 -> no effect; a later read of 0x20 returns its prior contents.
- Address errors:
  - Read 0x00000013 (misaligned) -> dm_addr_error=1, dm_read_data=0.
  - Write 0x00001000 (out of range for DEPTH_LOG2=10) -> dm_addr_error=1, array unchanged.
- Reset mid-write: write 0xCAFEF00D to 0x40, assert reset before completion -> no dm_resp_valid; a subsequent read of 0x40 returns the old value.
- DM_BYTE_ENABLE_EN: word 0x40 = 0xAABBCCDD, write 0x11223344 with dm_byte_en=4'b0101 -> read 0x40 returns 0xAA22CC44.
